aux_router: RTL

//  Parametrised CPU aux-bus router: decodes cpu_aux_addr[31:16] against N_TGT target bases
//  and forwards each request, registered, to one memory-mapped target (hwregs, iram, ...).

---
 rtl/aux_router.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/aux_router.sv
// aux_router: CPU aux-bus address decoder and target request register,
// with per-source response FIFOs merged onto one response port by round-robin.
module aux_router #(
    parameter int unsigned          N_TGT     = 4,
    parameter logic [N_TGT*16-1:0]  TGT_BASE  = {16'hFFFF, 16'hE001, 16'hE000, 16'hE002},
    parameter int unsigned          RSP_DEPTH = 4,
    parameter logic [31:0]          ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cpu_aux_request,
    input  logic                cpu_aux_write,
    input  logic [31:0]         cpu_aux_addr,
    input  logic [3:0]          cpu_aux_wstrb,
    input  logic [31:0]         cpu_aux_wdata,
    input  logic                cpu_aux_abort,
    output logic                cpu_aux_rvalid,
    output logic [31:0]         cpu_aux_rdata,
    output logic [8:0]          cpu_aux_rtag,
    output logic                rsp_overflow,
    output logic [N_TGT-1:0]    tgt_request,
    output logic                tgt_write,
    output logic [15:0]         tgt_addr,
    output logic [3:0]          tgt_wmask,
    output logic [31:0]         tgt_wdata,
    input  logic [N_TGT-1:0]    tgt_rvalid,
    input  logic [N_TGT*9-1:0]  tgt_rtag,
    input  logic [N_TGT*32-1:0] tgt_rdata
);

    localparam int NS = N_TGT + 1;
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int PW = (NS > 1) ? $clog2(NS) : 1;
    localparam int EW = 41;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [N_TGT-1:0] hit;
    logic             mapped;
    logic [N_TGT-1:0] xreq_q;
    logic             twrite_q;
    logic [15:0]      taddr_q;
    logic [3:0]       twmask_q;
    logic [31:0]      twdata_q;
    logic             err_q;
    logic [8:0]       etag_q;

    logic [NS-1:0]    push;
    logic [EW-1:0]    pdata [NS];
    logic [NS-1:0]    empty;
    logic [NS-1:0]    full;
    logic [NS-1:0]    pop;
    logic [AW:0]      wp_q [NS];
    logic [AW:0]      rp_q [NS];
    logic [EW-1:0]    mem_q [NS][RSP_DEPTH];

    logic             pick;
    logic [PW-1:0]    win;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [EW-1:0]    rd;
    logic             ovf_q, ovf_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [8:0]       rtag_q;

    // Address decode: lowest-numbered matching target wins.
    always_comb begin
        hit    = '0;
        mapped = 1'b0;
        for (int i = 0; i < int'(N_TGT); i++) begin
            if (!mapped && cpu_aux_addr[31:16] == TGT_BASE[i*16 +: 16]) begin
                hit[i] = 1'b1;
                mapped = 1'b1;
            end
        end
    end

    // Request stage: one-cycle strobe, shared fields held between requests.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            xreq_q   <= '0;
            twrite_q <= 1'b0;
            taddr_q  <= '0;
            twmask_q <= '0;
            twdata_q <= '0;
            err_q    <= 1'b0;
            etag_q   <= '0;
        end else begin
            xreq_q <= cpu_aux_request ? hit : '0;
            err_q  <= cpu_aux_request && !cpu_aux_write && !mapped;
            if (cpu_aux_request && !cpu_aux_write && !mapped)
                etag_q <= cpu_aux_wdata[8:0];
            if (cpu_aux_request && mapped) begin
                twrite_q <= cpu_aux_write;
                taddr_q  <= cpu_aux_addr[15:0];
                twmask_q <= cpu_aux_wstrb;
                twdata_q <= cpu_aux_wdata;
            end
        end
    end

    assign tgt_request = xreq_q & {N_TGT{!cpu_aux_abort}};
    assign tgt_write   = twrite_q;
    assign tgt_addr    = taddr_q;
    assign tgt_wmask   = twmask_q;
    assign tgt_wdata   = twdata_q;

    // Push sources and FIFO status; the error source is the last one.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            push[i]  = 1'b0;
            pdata[i] = '0;
            empty[i] = (wp_q[i] == rp_q[i]);
            full[i]  = (wp_q[i][AW] != rp_q[i][AW]) &&
                       (wp_q[i][AW-1:0] == rp_q[i][AW-1:0]);
        end
        for (int i = 0; i < int'(N_TGT); i++) begin
            push[i]  = tgt_rvalid[i];
            pdata[i] = {tgt_rdata[i*32 +: 32], tgt_rtag[i*9 +: 9]};
        end
        push[NS-1]  = err_q && !cpu_aux_abort;
        pdata[NS-1] = {ERR_DATA, etag_q};
    end

    // Round-robin pick: first non-empty source at or after the pointer.
    always_comb begin
        int idx;
        pick  = 1'b0;
        win   = '0;
        pop   = '0;
        ptr_d = ptr_q;
        for (int k = 0; k < NS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NS)
                idx = idx - NS;
            if (!pick && !empty[idx]) begin
                pick = 1'b1;
                win  = PW'(idx);
            end
        end
        if (pick) begin
            pop[win] = 1'b1;
            ptr_d    = (win == PW'(NS - 1)) ? '0 : win + 1'b1;
        end
        rd    = mem_q[win][rp_q[win][AW-1:0]];
        ovf_d = ovf_q || (|(push & full & ~pop));
    end

    // FIFO storage: a full FIFO still accepts a push when popped this cycle.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NS; i++)
            if (push[i] && (!full[i] || pop[i]))
                mem_q[i][wp_q[i][AW-1:0]] <= pdata[i];
    end

    // FIFO pointers, arbiter pointer, sticky overflow and response register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                wp_q[i] <= '0;
                rp_q[i] <= '0;
            end
            ptr_q    <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rtag_q   <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (push[i] && (!full[i] || pop[i]))
                    wp_q[i] <= wp_q[i] + PTR_ONE;
                if (pop[i])
                    rp_q[i] <= rp_q[i] + PTR_ONE;
            end
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            rvalid_q <= pick;
            rdata_q  <= pick ? rd[EW-1:9] : '0;
            rtag_q   <= pick ? rd[8:0] : '0;
        end
    end

    assign cpu_aux_rvalid = rvalid_q;
    assign cpu_aux_rdata  = rdata_q;
    assign cpu_aux_rtag   = rtag_q;
    assign rsp_overflow   = ovf_q;

endmodule
